// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM states and load-source encoding.
// Imported by prog_loader.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        WAKE     = 2'd0,
        ROM_FILL = 2'd1,
        STREAM   = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic MODE_ROM    = 1'b0;
    localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/prog_loader.sv
// Copies the program ROM (after a wake delay) or a byte stream into program memory.
// Latency: ROM word k is written 2 cycles after rom_addr=k; a stream word 1 cycle after acceptance.
// Backpressure: s_ready is high only in STREAM; no stall is ever applied on the write side.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 13,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    PROG_LEN      = 1024,
    parameter int                    WAKEUP_CYCLES = 512,
    parameter logic [DATA_WIDTH-1:0] TERMINATOR    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  mode,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  prog_we,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [DATA_WIDTH-1:0] prog_wr,
    output logic                  loaded,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   load_len,
    output logic                  overflow
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int WAKE_W = (WAKEUP_CYCLES > 1) ? $clog2(WAKEUP_CYCLES) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_C     = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PROG_LEN_C  = (ADDR_WIDTH+1)'(PROG_LEN);
    localparam logic [ADDR_WIDTH:0] PROG_LAST_C = (ADDR_WIDTH+1)'(PROG_LEN - 1);
    localparam logic [WAKE_W-1:0]   WAKE_LAST_C = WAKE_W'(WAKEUP_CYCLES - 1);

    if (PROG_LEN < 1 || PROG_LEN > DEPTH) begin : g_bad_prog_len
        $error("prog_loader: PROG_LEN must be within 1..2**ADDR_WIDTH");
    end
    if (WAKEUP_CYCLES < 1) begin : g_bad_wakeup
        $error("prog_loader: WAKEUP_CYCLES must be at least 1");
    end

    state_t                state_q, state_d;
    logic [WAKE_W-1:0]     wake_cnt_q, wake_cnt_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  s_ready_q, s_ready_d;
    logic                  prog_we_q, prog_we_d;
    logic [ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
    logic [DATA_WIDTH-1:0] prog_wr_q, prog_wr_d;
    logic                  loaded_q, loaded_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH:0]   load_len_q, load_len_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        state_d     = state_q;
        wake_cnt_d  = wake_cnt_q;
        count_d     = count_q;
        rom_addr_d  = rom_addr_q;
        rd_vld_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        s_ready_d   = s_ready_q;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_wr_d   = prog_wr_q;
        loaded_d    = loaded_q;
        busy_d      = busy_q;
        load_len_d  = load_len_q;
        overflow_d  = overflow_q;

        // ROM read data arrives one cycle after the address; register it as the write.
        if (rd_vld_q) begin
            prog_we_d   = 1'b1;
            prog_addr_d = rd_addr_q;
            prog_wr_d   = rom_data;
        end

        unique case (state_q)
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST_C) begin
                    state_d    = ROM_FILL;
                    busy_d     = 1'b1;
                    count_d    = '0;
                    rom_addr_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end
            ROM_FILL: begin
                if (count_q < PROG_LEN_C) begin
                    rd_vld_d  = 1'b1;
                    rd_addr_d = rom_addr_q;
                    count_d   = count_q + (ADDR_WIDTH+1)'(1);
                    if (count_q < PROG_LAST_C) begin
                        rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                    end
                end else if (!rd_vld_q) begin
                    // Last read has drained into the write register.
                    state_d    = DONE;
                    loaded_d   = 1'b1;
                    busy_d     = 1'b0;
                    load_len_d = PROG_LEN_C;
                end
            end
            STREAM: begin
                if (s_valid && s_ready_q) begin
                    if (s_data == TERMINATOR) begin
                        state_d    = DONE;
                        s_ready_d  = 1'b0;
                        loaded_d   = 1'b1;
                        busy_d     = 1'b0;
                        load_len_d = count_q;
                    end else if (count_q < DEPTH_C) begin
                        prog_we_d   = 1'b1;
                        prog_addr_d = count_q[ADDR_WIDTH-1:0];
                        prog_wr_d   = s_data;
                        count_d     = count_q + (ADDR_WIDTH+1)'(1);
                    end else begin
                        state_d    = DONE;
                        s_ready_d  = 1'b0;
                        overflow_d = 1'b1;
                        loaded_d   = 1'b1;
                        busy_d     = 1'b0;
                        load_len_d = count_q;
                    end
                end
            end
            DONE: begin
                if (load_req) begin
                    loaded_d   = 1'b0;
                    overflow_d = 1'b0;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    if (mode == MODE_STREAM) begin
                        state_d   = STREAM;
                        s_ready_d = 1'b1;
                    end else begin
                        state_d    = ROM_FILL;
                        rom_addr_d = '0;
                    end
                end
            end
            default: state_d = WAKE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= WAKE;
            wake_cnt_q  <= '0;
            count_q     <= '0;
            rom_addr_q  <= '0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            s_ready_q   <= 1'b0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_wr_q   <= '0;
            loaded_q    <= 1'b0;
            busy_q      <= 1'b0;
            load_len_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wake_cnt_q  <= wake_cnt_d;
            count_q     <= count_d;
            rom_addr_q  <= rom_addr_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            s_ready_q   <= s_ready_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_wr_q   <= prog_wr_d;
            loaded_q    <= loaded_d;
            busy_q      <= busy_d;
            load_len_q  <= load_len_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign s_ready   = s_ready_q;
    assign prog_we   = prog_we_q;
    assign prog_addr = prog_addr_q;
    assign prog_wr   = prog_wr_q;
    assign loaded    = loaded_q;
    assign busy      = busy_q;
    assign load_len  = load_len_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: auto ROM load, stream reloads, overflow, ignored requests, reset mid-load.
module tb_prog_loader;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_req = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_wr;
    logic          loaded;
    logic          busy;
    logic [AW:0]   load_len;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    prog_loader #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .PROG_LEN     (4),
        .WAKEUP_CYCLES(8),
        .TERMINATOR   (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load_req (load_req),
        .mode     (mode),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_wr  (prog_wr),
        .loaded   (loaded),
        .busy     (busy),
        .load_len (load_len),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        case (a)
            2'd0:    rom_word = 8'hA1;
            2'd1:    rom_word = 8'hB2;
            2'd2:    rom_word = 8'hC3;
            default: rom_word = 8'hD4;
        endcase
    endfunction

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {prog_we, prog_addr, prog_wr, rom_addr, s_ready, loaded, busy, load_len, overflow}, 32'h0);
    endtask

    task automatic expect_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk(tag, {prog_we, prog_addr, prog_wr}, {1'b1, a, d});
    endtask

    task automatic auto_load(input bit poke);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("wake_idle", {busy, loaded, prog_we}, 3'b000);
            load_req = poke && (i == 3);
            mode     = 1'b1;
        end
        load_req = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("fill_busy", {busy, loaded}, 2'b10);
            if (k < 4) chk("fill_rom_addr", rom_addr, k);
            if (k >= 2) expect_wr("fill_wr", AW'(k - 2), rom_word(AW'(k - 2)));
            else        chk("fill_no_wr", prog_we, 1'b0);
            load_req = poke && (k == 1);
            mode     = (k == 1) ? 1'b1 : 1'b0;
            tick();
        end
        load_req = 1'b0;
        chk("fill_done", {loaded, busy, prog_we, overflow}, 4'b1000);
        chk("fill_len", load_len, 4);
    endtask

    initial begin
        #12;
        chk_reset_vals("reset_vals");
        auto_load(1'b0);

        // Stream reload 11, 22, terminator.
        load_req = 1'b1; mode = 1'b1;
        tick();
        load_req = 1'b0;
        chk("stream_start", {busy, s_ready, loaded}, 3'b110);
        s_valid = 1'b1; s_data = 8'h11;
        tick();
        expect_wr("stream_w0", 2'd0, 8'h11);
        s_data = 8'h22;
        tick();
        expect_wr("stream_w1", 2'd1, 8'h22);
        s_data = 8'h00;
        tick();
        s_valid = 1'b0;
        chk("stream_term", {prog_we, loaded, busy, s_ready}, 4'b0100);
        chk("stream_len", load_len, 2);

        // Stream with a one-cycle gap after every word.
        load_req = 1'b1; mode = 1'b1;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 8'h33 + 8'(i * 17);
            tick();
            expect_wr("gap_wr", AW'(i), 8'h33 + 8'(i * 17));
            s_valid = 1'b0;
            tick();
            chk("gap_idle", {prog_we, s_ready}, 2'b01);
        end
        s_valid = 1'b1; s_data = 8'h00;
        tick();
        s_valid = 1'b0;
        chk("gap_done", {loaded, load_len}, {1'b1, 3'd3});

        // Overflow: five non-terminator words into a 4-word memory.
        load_req = 1'b1; mode = 1'b1;
        tick();
        load_req = 1'b0;
        chk("ovf_start", {loaded, overflow}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 8'(i + 1);
            tick();
            expect_wr("ovf_wr", AW'(i), 8'(i + 1));
        end
        s_data = 8'h05;
        tick();
        s_valid = 1'b0;
        chk("ovf_drop", {prog_we, overflow, loaded, s_ready}, 4'b0110);
        chk("ovf_len", load_len, 4);

        // ROM reload from DONE clears overflow and restarts at address 0.
        load_req = 1'b1; mode = 1'b0;
        tick();
        load_req = 1'b0;
        chk("rom_reload_start", {busy, overflow, loaded, rom_addr}, {3'b100, 2'd0});
        tick();
        tick();
        expect_wr("rom_reload_w0", 2'd0, 8'hA1);
        repeat (4) tick();
        chk("rom_reload_done", {loaded, busy, load_len}, {2'b10, 3'd4});

        // Reset in the middle of a stream load.
        load_req = 1'b1; mode = 1'b1;
        tick();
        load_req = 1'b0;
        s_valid = 1'b1; s_data = 8'h5A;
        tick();
        expect_wr("rst_pre_w0", 2'd0, 8'h5A);
        s_data = 8'h6B;
        tick();
        expect_wr("rst_pre_w1", 2'd1, 8'h6B);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("reset_async");
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset_held");

        // Full auto load again, with requests during WAKE and ROM_FILL.
        auto_load(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

- Fills program memory with a program before the CPU runs.
- After reset, waits a fixed number of cycles, then copies the built-in program ROM into program memory.
- On request, reloads program memory from either the ROM or a byte stream (e.g. UART receiver), with the source selected at run time.
- Sits between the program ROM or stream source and the program-memory write port; `loaded` gates the CPU's start.

## Interface
Parameters:
- ADDR_WIDTH, 13, program memory address width; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, program word width
- PROG_LEN, 1024, number of ROM words copied, 1..DEPTH (elaboration-time assertion)
- WAKEUP_CYCLES, 512, idle cycles after reset before the automatic ROM load
- TERMINATOR, 0, stream word value that ends a stream load; it is never written

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- load_req  in  1  single-cycle request to start a reload
- mode  in  1  source for load_req: 0 = ROM, 1 = stream; sampled only with load_req
- rom_addr  out  ADDR_WIDTH  program ROM read address
- rom_data  in  DATA_WIDTH  ROM read data, valid 1 cycle after rom_addr
- s_valid  in  1  stream word valid
- s_data  in  DATA_WIDTH  stream word
- s_ready  out  1  loader accepts a stream word this cycle
- prog_we  out  1  program memory write enable
- prog_addr  out  ADDR_WIDTH  program memory write address
- prog_wr  out  DATA_WIDTH  program memory write data
- loaded  out  1  program memory holds a complete program
- busy  out  1  a load is in progress (WAKE excluded)
- load_len  out  ADDR_WIDTH+1  number of words written by the last load
- overflow  out  1  last stream load exceeded DEPTH

## Operation
State values:
- WAKE: counts WAKEUP_CYCLES, then enters ROM_FILL; load_req is ignored.
- ROM_FILL: rom_addr steps 0..PROG_LEN-1, one per cycle. Word k is written to prog_addr k. The state then enters DONE with load_len = PROG_LEN.
- STREAM: s_ready = 1. Each accepted word (s_valid & s_ready):
  - Word equal to TERMINATOR: enter DONE, no write.
  - Otherwise, if count < DEPTH: write the word at prog_addr = count, then count++.
  - Otherwise: drop the word, set overflow, enter DONE.
  - load_len = count on exit.
- DONE: loaded = 1. load_req with mode 0 enters ROM_FILL; with mode 1 it enters STREAM.

Load start rules:
- At the start of any load: clear loaded and overflow, zero count.
- load_req is ignored while busy.

Reset, asserted at any time:
- Forces WAKE and clears the wake counter.
- Any partially written program is abandoned; loaded stays 0 until the automatic ROM load completes.

## Timing
Reset values:
- prog_we = 0, prog_addr = 0, prog_wr = 0, rom_addr = 0
- s_ready = 0, loaded = 0, busy = 0, load_len = 0, overflow = 0

All outputs are registered.

Cycle counts:
- WAKE lasts exactly WAKEUP_CYCLES cycles after reset deasserts.
- ROM_FILL (cycle 0 = first cycle in the state):
  - rom_addr = k on cycle k.
  - prog_we = 1 with prog_addr = k and prog_wr = ROM[k] on cycle k+2.
  - loaded rises on cycle PROG_LEN+2; busy falls on the same cycle.
- STREAM:
  - A word accepted on cycle n appears on prog_we/prog_addr/prog_wr on cycle n+1.
  - After the terminator is accepted on cycle n, loaded = 1 on cycle n+1.
  - s_ready drops the cycle after the terminator or the overflow word is accepted.

Other rules:
- busy rises the cycle after load_req.
- prog_we is never high for two consecutive cycles at the same address.
- count and load_len saturate at DEPTH; no wrap-around.

## Structure
- Package prog_loader_pkg holds:
  - state_t enum {WAKE, ROM_FILL, STREAM, DONE}
  - MODE_ROM = 1'b0 and MODE_STREAM = 1'b1
- No sub-module. The wake counter, ROM pipeline stage and stream counter stay inline in prog_loader.

## Test plan
- Automatic load: PROG_LEN=4, WAKEUP_CYCLES=8, ROM = {A1, B2, C3, D4}.
  - 8 idle cycles after reset.
  - Writes (0,A1), (1,B2), (2,C3), (3,D4) on consecutive cycles.
  - loaded = 1 and load_len = 4 the next cycle.
- Stream reload: in DONE, load_req with mode=1, then stream 11, 22, 00.
  - Writes (0,11), (1,22); no write for 00.
  - loaded = 1 and load_len = 2.
- Stream with gaps: s_valid toggles every other cycle.
  - Writes occur only the cycle after each accepted word, with addresses contiguous.
- Overflow: ADDR_WIDTH=2, stream 5 non-zero words.
  - Words 0..3 are written; the 5th is dropped.
  - overflow = 1, load_len = 4, loaded = 1.
- Ignored requests: load_req during WAKE and during ROM_FILL.
  - Neither request has any effect.
  - The ROM load completes exactly as in the automatic-load case.
- Reset mid-load: assert reset during STREAM after 2 words.
  - All outputs return to their reset values immediately.
  - WAKE restarts, followed by a full ROM load.
